dmem_io_bridge: RTL and testbench

Memory-mapped I/O bridge between the processor's data-memory port and the dmem syncram. Ordinary loads and stores pass through to dmem. A 16-word window at the top of the 12-bit data address space is decoded instead into:
- a byte-wide transmit FIFO, drained by an external valid/ready consumer;
- a status register;
- a free-running cycle counter.

Read data is returned with the same one-clock latency as dmem, so the processor cannot tell the two apart.

---
 rtl/dmem_io_bridge_if.sv | 30 +++
 rtl/dmem_io_bridge.sv | 128 ++++++++++++
 tb/tb_dmem_io_bridge.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_io_bridge_if.sv
// Processor data-port / dmem / TX-consumer bundle seen by the I/O bridge.
//   slave  : bridge side (consumes cpu_*, dmem_q, tx_ready; drives the rest)
//   master : environment side (processor, dmem and byte consumer together)
interface dmem_io_bridge_if;
  logic        cpu_strobe;
  logic [11:0] cpu_address;
  logic [31:0] cpu_data;
  logic        cpu_wren;
  logic [31:0] cpu_q;
  logic [11:0] dmem_address;
  logic [31:0] dmem_data;
  logic        dmem_wren;
  logic [31:0] dmem_q;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        tx_overflow;

  modport slave (
    input  cpu_strobe, cpu_address, cpu_data, cpu_wren, dmem_q, tx_ready,
    output cpu_q, dmem_address, dmem_data, dmem_wren, tx_valid, tx_data,
           tx_overflow
  );

  modport master (
    output cpu_strobe, cpu_address, cpu_data, cpu_wren, dmem_q, tx_ready,
    input  cpu_q, dmem_address, dmem_data, dmem_wren, tx_valid, tx_data,
           tx_overflow
  );
endinterface

// File: rtl/dmem_io_bridge.sv
// Memory-mapped I/O bridge between the processor data port and dmem.
// Loads/stores pass through to dmem except in a 16-word window at IO_BASE,
// which holds a byte TX FIFO (+0), a status register (+1) and a free-running
// cycle counter (+2). I/O read data has the same 1-clock latency as dmem.
// Ports:
//   clock  : fast memory clock (same as dmem)
//   reset  : synchronous, active-high
//   bus    : dmem_io_bridge_if.slave (cpu_*, dmem_*, tx_* signals)
module dmem_io_bridge #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [11:0] IO_BASE    = 12'hFF0
) (
  input  logic             clock,
  input  logic             reset,
  dmem_io_bridge_if.slave  bus
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [3:0] OFF_TXDATA = 4'h0;
  localparam logic [3:0] OFF_STATUS = 4'h1;
  localparam logic [3:0] OFF_CYCLES = 4'h2;

  logic             io_sel;
  logic [3:0]       offset;
  logic             wr_qual;
  logic             fifo_empty;
  logic             fifo_full;
  logic             push;
  logic             pop;
  logic             ovf_set;
  logic             ovf_clr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [7:0]       mem [FIFO_DEPTH];
  logic             overflow;
  logic [31:0]      cycles;
  logic [31:0]      io_rdata;
  logic [31:0]      io_rdata_q;
  logic             sel_q;

  // Address decode and dmem passthrough (no added latency)
  assign io_sel           = (bus.cpu_address[11:4] == IO_BASE[11:4]);
  assign offset           = bus.cpu_address[3:0];
  assign bus.dmem_address = bus.cpu_address;
  assign bus.dmem_data    = bus.cpu_data;
  assign bus.dmem_wren    = bus.cpu_wren & ~io_sel;

  // Processor holds signals for several clocks; the strobe picks exactly one
  assign wr_qual = bus.cpu_strobe & bus.cpu_wren & io_sel;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));

  // Full is judged on the pre-edge count, so a same-clock pop cannot admit a push
  assign push    = wr_qual & (offset == OFF_TXDATA) & ~fifo_full;
  assign ovf_set = wr_qual & (offset == OFF_TXDATA) & fifo_full;
  assign ovf_clr = wr_qual & (offset == OFF_STATUS) & bus.cpu_data[2];
  assign pop     = ~fifo_empty & bus.tx_ready;

  // Head presentation depends only on registered state
  assign bus.tx_valid    = ~fifo_empty;
  assign bus.tx_data     = fifo_empty ? 8'h00 : mem[rd_ptr];
  assign bus.tx_overflow = overflow;

  // I/O register read mux, captured every clock
  always_comb begin
    io_rdata = '0;
    if (io_sel) begin
      case (offset)
        OFF_STATUS: io_rdata = {24'b0, 4'(count), 1'b0, overflow, fifo_full, fifo_empty};
        OFF_CYCLES: io_rdata = cycles;
        default:    io_rdata = '0;
      endcase
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO storage; contents are don't-care once count is cleared
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= bus.cpu_data[7:0];
  end

  // Sticky overflow; a set in the same clock as a clear wins
  always_ff @(posedge clock) begin
    if (reset)        overflow <= 1'b0;
    else if (ovf_set) overflow <= 1'b1;
    else if (ovf_clr) overflow <= 1'b0;
  end

  // Free-running cycle counter, wraps naturally
  always_ff @(posedge clock) begin
    if (reset) cycles <= '0;
    else       cycles <= cycles + 32'd1;
  end

  // Read path register, aligned with dmem's internal output register
  always_ff @(posedge clock) begin
    if (reset) begin
      sel_q      <= 1'b0;
      io_rdata_q <= '0;
    end else begin
      sel_q      <= io_sel;
      io_rdata_q <= io_rdata;
    end
  end

  assign bus.cpu_q = sel_q ? io_rdata_q : bus.dmem_q;

endmodule

// File: tb/tb_dmem_io_bridge.sv
// Bench for dmem_io_bridge: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a queue-based model.
module tb_dmem_io_bridge;

  localparam int unsigned DEPTH = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  dmem_io_bridge_if bus ();

  dmem_io_bridge #(.FIFO_DEPTH(DEPTH), .IO_BASE(12'hFF0)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  // dmem stand-in: registered read, old data on read-during-write
  bit [31:0] dmem_arr [4096];
  always @(posedge clock) begin
    bus.dmem_q <= dmem_arr[bus.dmem_address];
    if (bus.dmem_wren) dmem_arr[bus.dmem_address] <= bus.dmem_data;
  end

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: byte queue, sticky flag, counter, word array
  logic [7:0]  m_q[$];
  bit          m_ovf = 1'b0;
  int unsigned m_cyc = 0;
  logic [31:0] m_rdata = '0;
  bit [31:0]   m_mem [4096];

  function automatic logic [31:0] m_status();
    int n;
    n = m_q.size();
    return 32'((n % 16) * 16 + (m_ovf ? 4 : 0) + ((n == DEPTH) ? 2 : 0) + ((n == 0) ? 1 : 0));
  endfunction

  // Advance the model by one clock edge using the inputs held before it
  task automatic model_step();
    bit          io;
    logic [3:0]  off;
    logic [11:0] a;
    bit          qual;
    bit          was_full;
    a    = bus.cpu_address;
    io   = (a[11:4] == 8'hFF);
    off  = a[3:0];
    qual = bus.cpu_strobe && bus.cpu_wren && io;
    if (reset) begin
      m_rdata = m_mem[a];
      m_q.delete();
      m_ovf = 1'b0;
      m_cyc = 0;
    end else begin
      if (!io)              m_rdata = m_mem[a];
      else if (off == 4'h1) m_rdata = m_status();
      else if (off == 4'h2) m_rdata = m_cyc;
      else                  m_rdata = '0;
      was_full = (m_q.size() == DEPTH);
      if (m_q.size() != 0 && bus.tx_ready) void'(m_q.pop_front());
      if (qual && off == 4'h1 && bus.cpu_data[2]) m_ovf = 1'b0;
      if (qual && off == 4'h0) begin
        if (was_full) m_ovf = 1'b1;
        else          m_q.push_back(bus.cpu_data[7:0]);
      end
      m_cyc = m_cyc + 1;
    end
    if (bus.cpu_wren && !io) m_mem[a] = bus.cpu_data;
  endtask

  // Per-cycle comparison against the model
  always @(negedge clock) begin
    if (chk_en) begin
      check("tx_valid", 32'(bus.tx_valid), 32'(m_q.size() != 0));
      check("tx_data", 32'(bus.tx_data), (m_q.size() != 0) ? 32'(m_q[0]) : 32'h0);
      check("tx_overflow", 32'(bus.tx_overflow), 32'(m_ovf));
      check("cpu_q", bus.cpu_q, m_rdata);
      check("dmem_wren", 32'(bus.dmem_wren),
            32'(bus.cpu_wren && (bus.cpu_address[11:4] != 8'hFF)));
      check("dmem_address", 32'(bus.dmem_address), 32'(bus.cpu_address));
      check("dmem_data", bus.dmem_data, bus.cpu_data);
    end
  end

  task automatic tick();
    @(posedge clock);
    model_step();
    #2;
  endtask

  task automatic io_write(input logic [11:0] a, input logic [31:0] d);
    bus.cpu_address = a;
    bus.cpu_data    = d;
    bus.cpu_wren    = 1'b1;
    bus.cpu_strobe  = 1'b1;
    tick();
    bus.cpu_strobe  = 1'b0;
    tick();
    bus.cpu_wren    = 1'b0;
  endtask

  task automatic do_read(input logic [11:0] a, output logic [31:0] d);
    bus.cpu_address = a;
    bus.cpu_wren    = 1'b0;
    bus.cpu_strobe  = 1'b0;
    tick();
    d = bus.cpu_q;
  endtask

  logic [31:0] rd;
  int r;

  initial begin
    bus.cpu_strobe  = 1'b0;
    bus.cpu_address = 12'h000;
    bus.cpu_data    = '0;
    bus.cpu_wren    = 1'b0;
    bus.tx_ready    = 1'b0;

    // Reset state
    repeat (3) tick();
    chk_en = 1'b1;
    check("rst_tx_valid", 32'(bus.tx_valid), 32'h0);
    check("rst_tx_data", 32'(bus.tx_data), 32'h0);
    check("rst_overflow", 32'(bus.tx_overflow), 32'h0);
    check("rst_cpu_q", bus.cpu_q, 32'h0);
    reset = 1'b0;

    // Passthrough
    bus.cpu_address = 12'h010;
    bus.cpu_data    = 32'hDEADBEEF;
    bus.cpu_wren    = 1'b1;
    bus.cpu_strobe  = 1'b1;
    #1;
    check("pt_dmem_wren", 32'(bus.dmem_wren), 32'h1);
    tick();
    bus.cpu_strobe = 1'b0;
    tick();
    bus.cpu_wren = 1'b0;
    do_read(12'h010, rd);
    check("pt_load", rd, 32'hDEADBEEF);
    bus.cpu_address = 12'hFF5;
    bus.cpu_wren    = 1'b1;
    #1;
    check("pt_io_no_wren", 32'(bus.dmem_wren), 32'h0);
    bus.cpu_wren = 1'b0;
    tick();

    // Single push and drain
    io_write(12'hFF0, 32'h41);
    check("push_valid", 32'(bus.tx_valid), 32'h1);
    check("push_data", 32'(bus.tx_data), 32'h41);
    do_read(12'hFF1, rd);
    check("push_status", rd, 32'h10);
    bus.tx_ready = 1'b1;
    tick();
    bus.tx_ready = 1'b0;
    check("drain_valid", 32'(bus.tx_valid), 32'h0);
    do_read(12'hFF1, rd);
    check("drain_status", rd, 32'h01);

    // Strobe qualification: one strobe over a 4-clock held store
    bus.cpu_address = 12'hFF0;
    bus.cpu_data    = 32'h55;
    bus.cpu_wren    = 1'b1;
    bus.cpu_strobe  = 1'b1;
    tick();
    bus.cpu_strobe = 1'b0;
    repeat (3) tick();
    bus.cpu_wren = 1'b0;
    do_read(12'hFF1, rd);
    check("strobe_count", rd, 32'h10);
    bus.tx_ready = 1'b1;
    tick();
    bus.tx_ready = 1'b0;

    // Fill past full, drain in order, clear overflow
    for (int i = 0; i < 9; i++) io_write(12'hFF0, 32'(i));
    do_read(12'hFF1, rd);
    check("fill_status", rd, 32'h86);
    bus.tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("drain_order", 32'(bus.tx_data), 32'(i));
      tick();
    end
    bus.tx_ready = 1'b0;
    check("drain_empty", 32'(bus.tx_valid), 32'h0);
    io_write(12'hFF1, 32'h4);
    check("ovf_cleared", 32'(bus.tx_overflow), 32'h0);

    // Full with a simultaneous pop: push is still dropped
    for (int i = 0; i < 8; i++) io_write(12'hFF0, 32'(8'h10 + i));
    bus.cpu_address = 12'hFF0;
    bus.cpu_data    = 32'hAA;
    bus.cpu_wren    = 1'b1;
    bus.cpu_strobe  = 1'b1;
    bus.tx_ready    = 1'b1;
    tick();
    bus.cpu_strobe = 1'b0;
    bus.tx_ready   = 1'b0;
    tick();
    bus.cpu_wren = 1'b0;
    check("fullpop_ovf", 32'(bus.tx_overflow), 32'h1);
    check("fullpop_head", 32'(bus.tx_data), 32'h11);
    do_read(12'hFF1, rd);
    check("fullpop_status", rd, 32'h74);

    // Reset mid-drain, then cycle counter
    io_write(12'hFF1, 32'h4);
    bus.tx_ready = 1'b1;
    repeat (2) tick();
    reset = 1'b1;
    tick();
    check("midrst_valid", 32'(bus.tx_valid), 32'h0);
    check("midrst_data", 32'(bus.tx_data), 32'h0);
    reset = 1'b0;
    bus.tx_ready = 1'b0;
    do_read(12'hFF1, rd);
    check("midrst_status", rd, 32'h01);
    bus.cpu_address = 12'h000;
    repeat (8) tick();
    do_read(12'hFF2, rd);
    check("cycles_10", rd, 32'd9);

    // Randomized traffic
    for (int n = 0; n < 2500; n++) begin
      r = $urandom_range(0, 9);
      if (r < 4)       bus.cpu_address = 12'hFF0;
      else if (r < 6)  bus.cpu_address = 12'hFF1;
      else if (r == 6) bus.cpu_address = 12'hFF2;
      else if (r == 7) bus.cpu_address = 12'hFF0 | 12'($urandom_range(0, 15));
      else             bus.cpu_address = 12'($urandom_range(0, 15));
      bus.cpu_data   = $urandom;
      bus.cpu_wren   = ($urandom_range(0, 1) == 1);
      bus.cpu_strobe = ($urandom_range(0, 3) == 0);
      bus.tx_ready   = ($urandom_range(0, 2) == 0);
      reset          = ($urandom_range(0, 299) == 0);
      tick();
    end
    reset = 1'b0;
    bus.cpu_wren   = 1'b0;
    bus.cpu_strobe = 1'b0;
    tick();

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
